// File: rtl/serial_compare_scheduler_pkg.sv
// serial_cmp_pkg: scheduler state encoding, one-hot result codes and index-width helper
package serial_cmp_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;
    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_LT = 3'b010;
    localparam logic [2:0] CMP_EQ = 3'b001;
    function automatic int idx_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction
endpackage

// File: rtl/serial_compare_scheduler_if.sv
// serial_compare_scheduler_if: two request channels and one tagged response channel
interface serial_compare_scheduler_if #(parameter int WIDTH = 8);
    logic             req0_valid, req1_valid, req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             resp_valid, resp_ready, resp_id, resp_gt, resp_lt, resp_eq;
    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, resp_ready,
        input  req0_ready, req1_ready, resp_valid, resp_id, resp_gt, resp_lt, resp_eq
    );
    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, resp_ready,
        output req0_ready, req1_ready, resp_valid, resp_id, resp_gt, resp_lt, resp_eq
    );
endinterface

// File: rtl/serial_compare_scheduler_core.sv
// serial_cmp_core: sticky MSB-first bit-serial magnitude comparator
module serial_cmp_core (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    input  logic x_i,
    input  logic y_i,
    output logic gt_o,
    output logic lt_o
);
    logic gt_q, gt_d, lt_q, lt_d;
    // first differing bit decides; later bits are ignored until cleared
    always_comb begin
        gt_d = clr_i ? 1'b0 : (en_i && !gt_q && !lt_q) ? (x_i & ~y_i) : gt_q;
        lt_d = clr_i ? 1'b0 : (en_i && !gt_q && !lt_q) ? (~x_i & y_i) : lt_q;
    end
    // result flags
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            gt_q <= 1'b0;
            lt_q <= 1'b0;
        end else begin
            gt_q <= gt_d;
            lt_q <= lt_d;
        end
    assign gt_o = gt_q;
    assign lt_o = lt_q;
endmodule

// File: rtl/serial_compare_scheduler.sv
// serial_compare_scheduler: round-robin sharing of one bit-serial comparator; SERIAL_CMP_EARLY_EXIT_EN ends SHIFT at the first differing bit
module serial_compare_scheduler
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    serial_compare_scheduler_if.slave     bus,
    output logic                          busy_o
);
    localparam int IW = idx_width(WIDTH);
    state_t           state_q, state_d;
    logic             ptr_q, ptr_d, id_q, id_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             gnt0, gnt1, clr, en, gt, lt;
    logic [2:0]       res;
    // arbitration, operand shifting and state sequencing
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        clr     = 1'b0;
        en      = 1'b0;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        case (state_q)
            IDLE: begin
                gnt0 = bus.req0_valid & (~ptr_q | ~bus.req1_valid);
                gnt1 = bus.req1_valid & (ptr_q | ~bus.req0_valid);
                if (gnt0 || gnt1) begin
                    id_d    = gnt1;
                    ptr_d   = ~gnt1;
                    a_d     = gnt1 ? bus.req1_a : bus.req0_a;
                    b_d     = gnt1 ? bus.req1_b : bus.req0_b;
                    idx_d   = IW'(WIDTH - 1);
                    clr     = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                en      = 1'b1;
                a_d     = a_q << 1;
                b_d     = b_q << 1;
                idx_d   = idx_q - 1'b1;
                state_d = (idx_q == '0) ? RESP : SHIFT;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
                if (a_q[WIDTH-1] != b_q[WIDTH-1]) state_d = RESP;
`endif
            end
            RESP:    state_d = bus.resp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    // scheduler registers
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            id_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
        end
    serial_cmp_core u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr),
        .en_i  (en),
        .x_i   (a_q[WIDTH-1]),
        .y_i   (b_q[WIDTH-1]),
        .gt_o  (gt),
        .lt_o  (lt)
    );
    assign res            = (state_q != RESP) ? 3'b000 : gt ? CMP_GT : lt ? CMP_LT : CMP_EQ;
    assign {bus.resp_gt, bus.resp_lt, bus.resp_eq} = res;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_id    = bus.resp_valid & id_q;
    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign busy_o         = (state_q != IDLE);
endmodule

// File: tb/tb_serial_compare_scheduler.sv
// tb_serial_compare_scheduler: table, hand-written and random checks against a behavioural model
module tb_serial_compare_scheduler;
    localparam int W = 8;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, busy1;
    int   total = 0;
    int   bad = 0;
    bit   mptr = 1'b0;

    always #5 clk = ~clk;

    serial_compare_scheduler_if #(.WIDTH(W)) bus ();
    serial_compare_scheduler_if #(.WIDTH(1)) bus1 ();

    serial_compare_scheduler #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave), .busy_o(busy));
    serial_compare_scheduler #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave), .busy_o(busy1));

    typedef struct {
        bit         v0, v1;
        logic [7:0] a0, b0, a1, b1;
        bit         gid, gt, lt, eq;
    } vec_t;
    vec_t tbl[4];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // cycles from accept edge to first resp_valid, from the MSB-first rule
    function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
        int first = W;
        for (int p = W - 1; p >= 0; p--)
            if (a[W-1-p] != b[W-1-p]) first = p;
        return (EARLY && first < W) ? first + 2 : W + 1;
    endfunction

    // present valids, track the grant, wait for and check the response, optionally stall it
    task automatic do_op(input bit v0, input bit v1, input logic [W-1:0] a0, input logic [W-1:0] b0,
                         input logic [W-1:0] a1, input logic [W-1:0] b1, input int stall, input bit keep,
                         output bit gid, output bit g, output bit l, output bit e);
        int n;
        bit xg;
        logic [W-1:0] ea, eb;
        xg = (v0 && v1) ? mptr : v1;
        ea = xg ? a1 : a0;
        eb = xg ? b1 : b0;
        bus.req0_valid = v0; bus.req1_valid = v1;
        bus.req0_a = a0; bus.req0_b = b0; bus.req1_a = a1; bus.req1_b = b1;
        bus.resp_ready = 1'b0;
        #1;
        n = 0;
        while (!(bus.req0_ready || bus.req1_ready) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) begin
            chk("grant_timeout", 0, 1);
            return;
        end
        chk("one_ready", int'(bus.req0_ready && bus.req1_ready), 0);
        gid = bus.req1_ready;
        chk("grant_id", int'(gid), int'(xg));
        mptr = !xg;
        @(posedge clk); #1;
        if (!keep) begin
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
        end
        n = 1;
        while (!bus.resp_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!bus.resp_valid) begin
            chk("resp_timeout", 0, 1);
            return;
        end
        chk("latency", n, exp_lat(ea, eb));
        g = bus.resp_gt; l = bus.resp_lt; e = bus.resp_eq;
        chk("resp_id", int'(bus.resp_id), int'(xg));
        chk("resp_gt", int'(g), int'(ea > eb));
        chk("resp_lt", int'(l), int'(ea < eb));
        chk("resp_eq", int'(e), int'(ea == eb));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk("stall_hold", int'({bus.resp_valid, bus.resp_id, bus.resp_gt, bus.resp_lt, bus.resp_eq}),
                int'({1'b1, xg, ea > eb, ea < eb, ea == eb}));
            chk("stall_ready", int'({bus.req0_ready, bus.req1_ready}), 0);
        end
        bus.resp_ready = 1'b1;
        #1;
        chk("resp_cycle_ready", int'({bus.req0_ready, bus.req1_ready}), 0);
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit gid, g, l, e;
        int n;
        logic [W-1:0] ra, rb;
        logic a1b, b1b;
        bus.req0_valid = 0; bus.req1_valid = 0; bus.resp_ready = 0;
        bus.req0_a = 0; bus.req0_b = 0; bus.req1_a = 0; bus.req1_b = 0;
        bus1.req0_valid = 0; bus1.req1_valid = 0; bus1.resp_ready = 0;
        bus1.req0_a = 0; bus1.req0_b = 0; bus1.req1_a = 0; bus1.req1_b = 0;
        tbl[0] = '{1'b1, 1'b0, 8'hA5, 8'hA4, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h3C, 8'hC3, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 8'h7F, 8'h7F, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0};

        #12;
        chk("reset_outputs", int'({bus.resp_valid, bus.resp_id, bus.resp_gt, bus.resp_lt, bus.resp_eq, busy,
                                   bus.req0_ready, bus.req1_ready}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            do_op(tbl[i].v0, tbl[i].v1, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1, 0, 1'b0, gid, g, l, e);
            chk("tbl_id", int'(gid), int'(tbl[i].gid));
            chk("tbl_res", int'({g, l, e}), int'({tbl[i].gt, tbl[i].lt, tbl[i].eq}));
        end

        for (int i = 0; i < 4; i++) begin
            do_op(1'b1, 1'b1, 8'h10, 8'h10, 8'hFF, 8'h00, 0, i < 3, gid, g, l, e);
            chk("arb_grant", int'(gid), i % 2);
            chk("arb_res", int'({g, l, e}), (i % 2) ? 4 : 1);
        end

        do_op(1'b1, 1'b1, 8'h01, 8'h02, 8'h30, 8'h20, 5, 1'b1, gid, g, l, e);
        do_op(1'b0, 1'b1, 8'h01, 8'h02, 8'h30, 8'h20, 0, 1'b0, gid, g, l, e);

        bus.req0_valid = 1'b1; bus.req0_a = 8'h80; bus.req0_b = 8'h00;
        #1;
        chk("abort_grant", int'(bus.req0_ready), 1);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("abort_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", int'({bus.resp_valid, bus.resp_id, bus.resp_gt, bus.resp_lt, bus.resp_eq, busy,
                                   bus.req0_ready, bus.req1_ready}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mptr = 1'b0;
        do_op(1'b1, 1'b1, 8'h80, 8'h00, 8'h00, 8'h80, 0, 1'b0, gid, g, l, e);
        chk("post_reset_grant", int'(gid), 0);

        for (int i = 0; i < 40; i++) begin
            bit v0, v1;
            v0 = 1'($urandom);
            v1 = 1'($urandom);
            if (!v0 && !v1) v0 = 1'b1;
            ra = W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
            if (v1 && (!v0 || mptr)) do_op(v0, v1, W'($urandom), W'($urandom), ra, rb, $urandom_range(0, 2), 1'b0, gid, g, l, e);
            else do_op(v0, v1, ra, rb, W'($urandom), W'($urandom), $urandom_range(0, 2), 1'b0, gid, g, l, e);
        end

        for (int i = 0; i < 2; i++) begin
            a1b = 1'b1;
            b1b = (i == 0) ? 1'b0 : 1'b1;
            bus1.req0_valid = 1'b1; bus1.req0_a = a1b; bus1.req0_b = b1b;
            #1;
            chk("w1_ready", int'(bus1.req0_ready), 1);
            @(posedge clk); #1;
            bus1.req0_valid = 1'b0;
            n = 1;
            while (!bus1.resp_valid && n < 20) begin
                @(posedge clk); #1; n++;
            end
            chk("w1_latency", n, 2);
            chk("w1_res", int'({bus1.resp_gt, bus1.resp_lt, bus1.resp_eq}), (i == 0) ? 4 : 1);
            chk("w1_id", int'(bus1.resp_id), 0);
            bus1.resp_ready = 1'b1;
            @(posedge clk); #1;
            bus1.resp_ready = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
